// File: rtl/button_pulse_gen.sv
// Two-button front end: synchronise, debounce and edge-detect raw Push/Toggle pins into
// single-cycle command pulses, with hold-to-auto-repeat on Push and an up/down mode flag on Toggle.
module button_pulse_gen #(
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int DEBOUNCE_CYC     = 20000,
  parameter int REPEAT_DELAY_CYC = 10000000,
  parameter int REPEAT_RATE_CYC  = 2500000,
  parameter bit REPEAT_EN        = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Push_raw,
  input  logic       i_Toggle_raw,
  output logic       o_Push,
  output logic       o_Toggle,
  output logic       o_UpDnMode,
  output logic       o_Push_lvl,
  output logic [1:0] o_Push_state
);

  localparam int DW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RMAX   = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RW     = $clog2(RMAX);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } push_state_t;

  logic          push_in, tog_in;
  logic          push_s1, push_s2, tog_s1, tog_s2;
  logic          push_deb, tog_deb, push_deb_d, tog_deb_d;
  logic [DW-1:0] push_cnt, tog_cnt;
  logic [RW-1:0] rcnt;
  logic          push_rise, tog_rise;
  push_state_t   state;

  // Normalise to pressed = 1 so everything downstream is polarity-free.
  assign push_in = ACTIVE_LOW ? ~i_Push_raw   : i_Push_raw;
  assign tog_in  = ACTIVE_LOW ? ~i_Toggle_raw : i_Toggle_raw;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      push_s1 <= 1'b0;
      push_s2 <= 1'b0;
      tog_s1  <= 1'b0;
      tog_s2  <= 1'b0;
    end else begin
      push_s1 <= push_in;
      push_s2 <= push_s1;
      tog_s1  <= tog_in;
      tog_s2  <= tog_s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      push_deb <= 1'b0;
      push_cnt <= '0;
    end else if (push_s2 == push_deb) begin
      push_cnt <= '0;
    end else if (push_cnt == DEB_LAST) begin
      push_deb <= push_s2;
      push_cnt <= '0;
    end else begin
      push_cnt <= push_cnt + DW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tog_deb <= 1'b0;
      tog_cnt <= '0;
    end else if (tog_s2 == tog_deb) begin
      tog_cnt <= '0;
    end else if (tog_cnt == DEB_LAST) begin
      tog_deb <= tog_s2;
      tog_cnt <= '0;
    end else begin
      tog_cnt <= tog_cnt + DW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      push_deb_d <= 1'b0;
      tog_deb_d  <= 1'b0;
    end else begin
      push_deb_d <= push_deb;
      tog_deb_d  <= tog_deb;
    end
  end

  assign push_rise = push_deb & ~push_deb_d;
  assign tog_rise  = tog_deb & ~tog_deb_d;

  // Outputs are one-cycle strobes with no valid/ready back-pressure: the consumer must
  // take each pulse in the cycle it is high; o_UpDnMode is a level that changes with o_Toggle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Toggle   <= 1'b0;
      o_UpDnMode <= 1'b0;
    end else begin
      o_Toggle <= tog_rise;
      if (tog_rise) o_UpDnMode <= ~o_UpDnMode;
    end
  end

  // Release is tested before the timeout so a same-edge release never emits a pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= ST_IDLE;
      rcnt   <= '0;
      o_Push <= 1'b0;
    end else begin
      o_Push <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (push_rise) begin
            o_Push <= 1'b1;
            rcnt   <= '0;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!push_deb) begin
            state <= ST_IDLE;
          end else if (REPEAT_EN) begin
            if (rcnt == DELAY_LAST) begin
              o_Push <= 1'b1;
              rcnt   <= '0;
              state  <= ST_REPEAT;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (!push_deb) begin
            state <= ST_IDLE;
          end else if (rcnt == RATE_LAST) begin
            o_Push <= 1'b1;
            rcnt   <= '0;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_Push_lvl   = push_deb;
  assign o_Push_state = state;

endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Front end for the BCD counter board. Conditions two raw push-buttons (Push, Toggle) into clean single-cycle command pulses.
- Stages: 2-FF synchronise, debounce, edge-detect.
- The Push channel adds hold-to-auto-repeat. The Toggle channel also owns the up/down mode flag.
- Sits between the board pins and the counter chain. Drives the counter's count-enable pulse and mode level.

Parameters:
- ACTIVE_LOW, 1, 1 means a raw input level of 0 is "pressed"; 0 means a level of 1 is "pressed".
- DEBOUNCE_CYC, 20000, consecutive stable cycles required to accept a new debounced level (>=1).
- REPEAT_DELAY_CYC, 10000000, cycles from the first Push pulse to the first repeat pulse (>=2).
- REPEAT_RATE_CYC, 2500000, cycles between subsequent repeat pulses (>=2).
- REPEAT_EN, 1, 0 disables auto-repeat; Push then behaves like Toggle (one pulse per press).

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Push_raw  in  1  raw Push button pin; asynchronous and bouncing.
- i_Toggle_raw  in  1  raw Toggle button pin; asynchronous and bouncing.
- o_Push  out  1  one-cycle pulse per accepted press, plus auto-repeat pulses.
- o_Toggle  out  1  one-cycle pulse per accepted Toggle press.
- o_UpDnMode  out  1  0 = up, 1 = down; flips on each o_Toggle pulse.
- o_Push_lvl  out  1  debounced Push level, 1 = pressed.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser FFs and debounced registers load the "released" level.
  - Debounce and repeat counters go to 0; FSM goes to IDLE.
  - o_Push, o_Toggle, o_UpDnMode and o_Push_lvl all go to 0.
- Polarity: raw inputs are normalised to pressed = 1 before the synchroniser when ACTIVE_LOW = 1.
- Synchroniser: 2 flops per input (s1, s2). Nothing downstream reads s1.
- Debounce, per channel:
  - deb holds the accepted level. cnt increments on each edge where s2 != deb.
  - Any edge with s2 == deb clears cnt to 0.
  - When s2 != deb and cnt == DEBOUNCE_CYC-1, the next edge sets deb = s2 and cnt = 0.
  - Glitches shorter than DEBOUNCE_CYC cycles are never seen downstream.
- Latency:
  - Edge 1 is the first edge that samples a new stable raw level.
  - deb changes at edge DEBOUNCE_CYC+2.
  - The press pulse is registered high for exactly the cycle after edge DEBOUNCE_CYC+3.
- Toggle channel:
  - A rising edge of deb gives one o_Toggle pulse, and o_UpDnMode flips on the same edge as the pulse.
  - Release and hold produce nothing.
- Push FSM, states IDLE, HOLD, REPEAT:
  - IDLE: on a deb rising edge, pulse o_Push, clear rcnt, go to HOLD.
  - HOLD: deb = 0 goes to IDLE with no pulse. If rcnt == REPEAT_DELAY_CYC-1, pulse, clear rcnt, go to REPEAT. Otherwise rcnt++.
  - REPEAT: deb = 0 goes to IDLE. If rcnt == REPEAT_RATE_CYC-1, pulse and clear rcnt. Otherwise rcnt++.
  - REPEAT_EN = 0: HOLD never advances. It only returns to IDLE on release.
  - Release and timeout on the same edge: release wins, no pulse.
- Pulse spacing: the 2nd Push pulse comes exactly REPEAT_DELAY_CYC cycles after the 1st; later pulses are exactly REPEAT_RATE_CYC cycles apart.
- o_Push_lvl = Push deb, driven directly.
- Channels are independent. Simultaneous presses produce both pulses in the same cycle.
- o_Push and o_Toggle are never high two consecutive cycles.
- Reset mid-hold or mid-debounce:
  - Outputs drop immediately and o_UpDnMode returns to 0.
  - After release of reset, a button still held counts as a new press once debounced (pulse after DEBOUNCE_CYC+3 edges).
- Counter widths are sized by $clog2 of their max parameter. No wrap is possible, since every counter is cleared at its terminal value.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8, ACTIVE_LOW=1):
1. Reset: assert i_Rst mid-cycle with raw inputs at 0 (pressed) -> all outputs 0 asynchronously. Release reset -> first o_Push pulse after 7 edges, o_UpDnMode = 0 until the Toggle pulse.
2. Bounce: i_Push_raw toggles 1/0 every 2 cycles for 30 cycles, then holds 0 for 4 cycles, then 1 -> no pulse during the bounce; exactly one o_Push pulse on edge 7 of the stable-low window; o_Push_lvl high for 4 cycles.
3. Auto-repeat: hold i_Push_raw = 0 for 60 cycles -> o_Push pulses at relative cycles 0, 20, 28, 36, 44, 52 (6 pulses). Release -> no further pulses; FSM is IDLE.
4. Release race: release timed so deb falls on the same edge rcnt hits 19 -> no second pulse.
5. Toggle: three separate debounced presses of i_Toggle_raw, each held 50 cycles -> exactly 3 o_Toggle pulses; o_UpDnMode goes 0→1→0→1; no repeat while held.
6. Simultaneous: both raw inputs fall on the same edge -> o_Push and o_Toggle pulse in the same cycle; o_UpDnMode = 1. Glitch of 3 cycles on Toggle -> no pulse.
